// File: rtl/ddr5_phy_read_capture.sv
// DDR5 PHY read capture: decodes phase-0 READ commands, delays them through a
// read-latency pipeline and captures DQ bursts into the DFI read-data port.
module ddr5_phy_read_capture #(
    parameter int pDRAM_SIZE = 4,
    parameter int pNUM_RANK  = 1,
    parameter int pMAX_RL    = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [pNUM_RANK-1:0]    dfi_cs_n_p0,
    input  logic [13:0]             dfi_address_p0,
    input  logic [5:0]              rl_i,
    input  logic                    bl32_i,
    input  logic [2*pDRAM_SIZE-1:0] DQ,
    input  logic                    DQS_valid,
    output logic [2*pDRAM_SIZE-1:0] dfi_rddata_w0,
    output logic                    dfi_rddata_valid_w0,
    output logic                    rd_busy_o,
    output logic                    rd_err_o,
    output logic [7:0]              rd_err_cnt_o
);

    localparam int DW = 2 * pDRAM_SIZE;
    localparam int TW = $clog2(pMAX_RL);
    localparam logic [4:0] READ_OP = 5'b11101;

    typedef enum logic {IDLE, BURST} state_t;
    typedef struct packed {
        logic valid;
        logic bl32;
    } rd_entry_t;

    rd_entry_t      pipe_q [pMAX_RL];
    state_t         state_q, state_d;
    logic [4:0]     beat_cnt_q, beat_cnt_d;
    logic           second_half_q;
    logic [DW-1:0]  data_q;
    logic           valid_q;
    logic           err_q;
    logic [7:0]     err_cnt_q, err_cnt_d;
    logic [TW-1:0]  tap_sel;
    logic           cs_any;
    logic           rd_decode;
    logic           hit;
    logic           capture;
    logic           collision;
    logic           strobe_err;
    logic [1:0]     err_inc;
    logic [8:0]     err_sum;
    logic           busy;
    logic           addr_unused;

    assign addr_unused = ^dfi_address_p0[13:5];
    assign cs_any      = (dfi_cs_n_p0 != '1);
    assign rd_decode   = !second_half_q && cs_any && (dfi_address_p0[4:0] == READ_OP);
    assign hit         = pipe_q[0].valid;

    // Out-of-range latencies are clamped; the write tap is latency minus one.
    always_comb begin
        if (rl_i < 6'd2)
            tap_sel = TW'(1);
        else if (int'(rl_i) > pMAX_RL - 1)
            tap_sel = TW'(pMAX_RL - 2);
        else
            tap_sel = TW'(rl_i - 6'd1);
    end

    // NOTE: the pipeline is reset because busy is derived from its valid bits.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < pMAX_RL; i++)
                pipe_q[i] <= '0;
        end else begin
            for (int i = 0; i < pMAX_RL - 1; i++)
                pipe_q[i] <= pipe_q[i+1];
            pipe_q[pMAX_RL-1] <= '0;
            if (rd_decode)
                pipe_q[tap_sel] <= rd_entry_t'{valid: 1'b1, bl32: bl32_i};
        end
    end

    // The tap-0 cycle from IDLE is the first beat; beat_cnt holds beats left after it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        capture    = 1'b0;
        collision  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    capture    = 1'b1;
                    beat_cnt_d = pipe_q[0].bl32 ? 5'd15 : 5'd7;
                    state_d    = BURST;
                end
            end
            BURST: begin
                capture    = 1'b1;
                collision  = hit;
                beat_cnt_d = beat_cnt_q - 5'd1;
                if (beat_cnt_q == 5'd1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign strobe_err = capture && !DQS_valid;
    assign err_inc    = {1'b0, collision} + {1'b0, strobe_err};
    assign err_sum    = {1'b0, err_cnt_q} + {7'd0, err_inc};
    assign err_cnt_d  = err_sum[8] ? 8'hFF : err_sum[7:0];

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            second_half_q <= 1'b0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            second_half_q <= cs_any;
            valid_q       <= capture;
            if (capture)
                data_q <= DQ;
            if (collision || strobe_err)
                err_q <= 1'b1;
            err_cnt_q     <= err_cnt_d;
        end
    end

    always_comb begin
        busy = (state_q != IDLE);
        for (int i = 0; i < pMAX_RL; i++)
            busy = busy | pipe_q[i].valid;
    end

    assign dfi_rddata_w0       = data_q;
    assign dfi_rddata_valid_w0 = valid_q;
    assign rd_busy_o           = busy;
    assign rd_err_o            = err_q;
    assign rd_err_cnt_o        = err_cnt_q;

endmodule
